// File: rtl/vga_sync_rx.sv
// VGA timing receiver: recovers pixel coordinates and data-enable from hsync/vsync,
// checks line/frame lengths against nominal timing and declares lock after clean frames.
module vga_sync_rx #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] pix_in,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        de,
  output logic [11:0] pix_out,
  output logic        frame_start,
  output logic        locked,
  output logic        err_line,
  output logic        err_frame
);

  localparam logic [9:0] H_FIRST = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_FIRST = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] H_END   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END   = 10'(V_TOTAL - 1);
  localparam logic [9:0] SAT     = 10'h3ff;
  localparam int         GFW     = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {UNLOCKED, TRAINING, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic [9:0]       pos_q, pos_d, line_q, line_d;
  logic             h_seen_q, h_seen_d, v_seen_q, v_seen_d, vpend_q, vpend_d;
  logic [GFW-1:0]   gf_q, gf_d;
  logic [9:0]       h_addr_q, h_addr_d, v_addr_q, v_addr_d;
  logic             de_q, de_d, fs_q, fs_d, locked_q, locked_d;
  logic             err_line_q, err_line_d, err_frame_q, err_frame_d;
  logic [11:0]      pix_q, pix_d;
  logic             hfall, vfall, qual, timeout, frame_done, err_any;

  always_comb begin
    hs_d  = hsync;
    vs_d  = vsync;
    hfall = hs_q & ~hsync;
    vfall = vs_q & ~vsync;
    qual  = hfall & (vpend_q | vfall);

    pos_d    = hfall ? 10'd0 : ((pos_q == SAT) ? pos_q : pos_q + 10'd1);
    // Timeout fires on the single cycle pos first lands on 1023; clearing h_seen
    // keeps the following hfall from reporting a second error.
    timeout  = h_seen_q & ~hfall & (pos_q == SAT - 10'd1);
    h_seen_d = hfall | (h_seen_q & ~timeout);
    err_line_d = (hfall & h_seen_q & (pos_q != H_END)) | timeout;

    line_d      = qual ? 10'd0 : ((hfall && line_q != SAT) ? line_q + 10'd1 : line_q);
    v_seen_d    = v_seen_q | qual;
    vpend_d     = ~qual & (vpend_q | vfall);
    frame_done  = qual & v_seen_q;
    err_frame_d = frame_done & (line_q != V_END);
    err_any     = err_line_d | err_frame_d;

    state_d = state_q;
    gf_d    = gf_q;
    unique case (state_q)
      UNLOCKED: if (vfall) begin
        state_d = TRAINING;
        gf_d    = '0;
      end
      TRAINING: if (err_any) begin
        state_d = UNLOCKED;
      end else if (frame_done) begin
        gf_d = gf_q + GFW'(1);
        if (gf_d == GFW'(LOCK_FRAMES)) state_d = LOCKED;
      end
      LOCKED: if (err_any) state_d = UNLOCKED;
      default: state_d = UNLOCKED;
    endcase

    // Next-state lock gates de so an error drops de on its own output cycle.
    locked_d = (state_d == LOCKED);
    de_d     = h_seen_d & v_seen_d & locked_d &
               (pos_d >= H_FIRST) & (pos_d <= H_LAST) &
               (line_d >= V_FIRST) & (line_d <= V_LAST);
    h_addr_d = de_d ? pos_d - H_FIRST : 10'd0;
    v_addr_d = de_d ? line_d - V_FIRST : 10'd0;
    fs_d     = qual;
    pix_d    = pix_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      pos_q       <= '0;
      line_q      <= '0;
      h_seen_q    <= 1'b0;
      v_seen_q    <= 1'b0;
      vpend_q     <= 1'b0;
      gf_q        <= '0;
      h_addr_q    <= '0;
      v_addr_q    <= '0;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      locked_q    <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      pos_q       <= pos_d;
      line_q      <= line_d;
      h_seen_q    <= h_seen_d;
      v_seen_q    <= v_seen_d;
      vpend_q     <= vpend_d;
      gf_q        <= gf_d;
      h_addr_q    <= h_addr_d;
      v_addr_q    <= v_addr_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      locked_q    <= locked_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
      pix_q       <= pix_d;
    end
  end

  assign h_addr      = h_addr_q;
  assign v_addr      = v_addr_q;
  assign de          = de_q;
  assign pix_out     = pix_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err_line    = err_line_q;
  assign err_frame   = err_frame_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx with a shrunken frame so whole frames fit in a short run;
// a timestamp/count reference model predicts every output cycle.
module tb_vga_sync_rx;
  localparam int HS = 4, HBP = 3, HA = 16, HT = 28;
  localparam int VS = 2, VBP = 3, VA = 10, VT = 18;
  localparam int LF = 2;
  localparam int FC = HT * VT;

  logic clk = 1'b0, rst = 1'b1, hsync = 1'b1, vsync = 1'b1;
  logic [11:0] pix_in = '0;
  logic [9:0]  h_addr, v_addr;
  logic [11:0] pix_out;
  logic        de, frame_start, locked, err_line, err_frame;
  wire  [36:0] obs = {h_addr, v_addr, de, pix_out, frame_start, locked, err_line, err_frame};

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  vga_sync_rx #(.H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
                .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT),
                .LOCK_FRAMES(LF)) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .pix_in(pix_in),
    .h_addr(h_addr), .v_addr(v_addr), .de(de), .pix_out(pix_out),
    .frame_start(frame_start), .locked(locked), .err_line(err_line), .err_frame(err_frame));

  // Reference model: position is the age of the last hsync fall, line is the number
  // of hsync falls since the last frame start, lock is a clean-frame tally.
  int  m_t = 0, m_last = 0, m_lines = 0, m_mode = 0, m_clean = 0, m_age = 0, m_pos = 0, m_ln = 0;
  bit  m_ph = 1, m_pv = 1, m_hv = 0, m_vv = 0, m_vp = 0;
  bit  m_hf, m_vf, m_q, m_done, m_el, m_ef, m_lk, m_de;
  logic [36:0] exp_vec = '0;

  always @(posedge clk) begin
    m_t++;
    if (rst) begin
      m_ph = 1; m_pv = 1; m_last = m_t; m_hv = 0; m_vv = 0; m_vp = 0;
      m_lines = 0; m_mode = 0; m_clean = 0; exp_vec = '0;
    end else begin
      m_hf = m_ph && !hsync;
      m_vf = m_pv && !vsync;
      m_ph = hsync;
      m_pv = vsync;
      m_age = m_t - m_last;
      m_el = 0; m_ef = 0;
      m_q = m_hf && (m_vp || m_vf);
      m_done = m_q && m_vv;
      if (m_hf) begin
        m_el = m_hv && (m_age != HT);
        m_last = m_t; m_hv = 1; m_pos = 0;
      end else begin
        m_pos = (m_age > 1023) ? 1023 : m_age;
        if (m_hv && m_age == 1023) begin m_el = 1; m_hv = 0; end
      end
      if (m_q) begin
        m_ef = m_vv && (m_lines != VT - 1);
        m_lines = 0; m_vv = 1; m_vp = 0;
      end else begin
        if (m_hf) m_lines++;
        if (m_vf) m_vp = 1;
      end
      m_ln = (m_lines > 1023) ? 1023 : m_lines;
      case (m_mode)
        0: if (m_vf) begin m_mode = 1; m_clean = 0; end
        1: if (m_el || m_ef) m_mode = 0;
           else if (m_done) begin m_clean++; if (m_clean == LF) m_mode = 2; end
        default: if (m_el || m_ef) m_mode = 0;
      endcase
      m_lk = (m_mode == 2);
      m_de = m_hv && m_vv && m_lk && m_pos >= HS + HBP && m_pos < HS + HBP + HA &&
             m_ln >= VS + VBP && m_ln < VS + VBP + VA;
      exp_vec = {m_de ? 10'(m_pos - HS - HBP) : 10'd0, m_de ? 10'(m_ln - VS - VBP) : 10'd0,
                 m_de, pix_in, m_q, m_lk, m_el, m_ef};
    end
  end

  // Stream generator: current frame plan plus position inside it.
  int g_p = 0, g_l = 0, f_lines = VT, f_short_l = -1, f_short_len = HT;
  bit rnd_pix = 0;

  function automatic void set_frame(input int nl, input int sl, input int slen);
    f_lines = nl; f_short_l = sl; f_short_len = slen;
  endfunction

  function automatic int frame_len();
    return f_lines * HT + ((f_short_l >= 0 && f_short_l < f_lines) ? f_short_len - HT : 0);
  endfunction

  function automatic void gen(output logic h, output logic v, output logic [11:0] px);
    int len;
    len = (g_l == f_short_l) ? f_short_len : HT;
    h = (g_p >= HS);
    v = (g_l >= VS);
    px = rnd_pix ? 12'($urandom) : {4'(g_p), 4'(g_l), 4'hA};
    g_p++;
    if (g_p == len) begin
      g_p = 0; g_l++;
      if (g_l == f_lines) g_l = 0;
    end
  endfunction

  task automatic step(input logic r, input logic h, input logic v, input logic [11:0] px);
    rst = r; hsync = h; vsync = v; pix_in = px;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 12'($urandom));
      total++;
      if (obs !== 37'd0) begin bad++; $display("FAIL reset_outputs c=%0d got %h want 0", c, obs); end
    end
  endtask

  task automatic test_nominal();
    logic h, v; logic [11:0] px; logic [9:0] th, tv;
    int lk_at = -1, first_de = -1, last_de = -1, de_cnt = 0, errs = 0;
    logic [19:0] f_addr = '1, l_addr = '1;
    g_p = 0; g_l = 0; rnd_pix = 0; set_frame(VT, -1, HT);
    for (int c = 0; c < 4 * FC; c++) begin
      gen(h, v, px); step(1'b0, h, v, px);
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL nominal_model c=%0d got %h want %h", c, obs, exp_vec); end
      total++;
      if (pix_out !== px) begin bad++; $display("FAIL pix_align c=%0d got %h want %h", c, pix_out, px); end
      if (de) begin
        th = h_addr + 10'(HS + HBP); tv = v_addr + 10'(VS + VBP);
        total++;
        if ({th[3:0], tv[3:0]} !== pix_out[11:4]) begin
          bad++; $display("FAIL addr_tag c=%0d got %h want %h", c, pix_out[11:4], {th[3:0], tv[3:0]});
        end
      end
      if (locked && lk_at < 0) lk_at = c;
      if (err_line || err_frame) errs++;
      if (c >= 2 * FC && c < 3 * FC && de) begin
        de_cnt++;
        if (first_de < 0) begin first_de = c; f_addr = {h_addr, v_addr}; end
        last_de = c; l_addr = {h_addr, v_addr};
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL nominal_errs got %0d want 0", errs); end
    total++; if (lk_at != 2 * FC) begin bad++; $display("FAIL lock_time got %0d want %0d", lk_at, 2 * FC); end
    total++;
    if (first_de != 2 * FC + (VS + VBP) * HT + HS + HBP || f_addr !== 20'd0) begin
      bad++; $display("FAIL first_de got %0d/%h want %0d/0", first_de, f_addr, 2 * FC + (VS + VBP) * HT + HS + HBP);
    end
    total++;
    if (last_de != 2 * FC + (VS + VBP + VA - 1) * HT + HS + HBP + HA - 1 || l_addr !== {10'(HA - 1), 10'(VA - 1)}) begin
      bad++; $display("FAIL last_de got %0d/%h want %0d/%h", last_de, l_addr,
                      2 * FC + (VS + VBP + VA - 1) * HT + HS + HBP + HA - 1, {10'(HA - 1), 10'(VA - 1)});
    end
    total++; if (de_cnt != HA * VA) begin bad++; $display("FAIL de_count got %0d want %0d", de_cnt, HA * VA); end
  endtask

  task automatic test_short_line();
    logic h, v; logic [11:0] px;
    int l0, el_cnt = 0, el_at = -1, lk_rise = -1, de_bad = 0;
    logic prev_lk, lk_before = 0, lk_err = 1, de_err = 1;
    set_frame(VT, 5, HT - 1); l0 = frame_len();
    prev_lk = locked;
    for (int c = 0; c < l0 + 3 * FC; c++) begin
      if (c == l0) set_frame(VT, -1, HT);
      gen(h, v, px); step(1'b0, h, v, px);
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL shortline_model c=%0d got %h want %h", c, obs, exp_vec); end
      if (err_line) begin
        el_cnt++;
        if (el_at < 0) begin el_at = c; lk_before = prev_lk; lk_err = locked; de_err = de; end
      end else if (el_at >= 0 && lk_rise < 0) begin
        if (locked) lk_rise = c;
        else if (de) de_bad++;
      end
      prev_lk = locked;
    end
    total++; if (el_cnt != 1) begin bad++; $display("FAIL shortline_count got %0d want 1", el_cnt); end
    total++; if (el_at != 6 * HT - 1) begin bad++; $display("FAIL shortline_at got %0d want %0d", el_at, 6 * HT - 1); end
    total++;
    if ({lk_before, lk_err, de_err} !== 3'b100) begin
      bad++; $display("FAIL shortline_drop got %b want 100", {lk_before, lk_err, de_err});
    end
    total++; if (de_bad != 0) begin bad++; $display("FAIL shortline_de got %0d want 0", de_bad); end
    total++; if (lk_rise != l0 + 2 * FC) begin bad++; $display("FAIL shortline_relock got %0d want %0d", lk_rise, l0 + 2 * FC); end
  endtask

  task automatic test_short_frame();
    logic h, v; logic [11:0] px;
    int l0, ef_cnt = 0, ef_at = -1, el_cnt = 0, lk_rise = -1;
    logic prev_lk, lk_before = 0, lk_err = 1;
    set_frame(VT - 1, -1, HT); l0 = frame_len();
    prev_lk = locked;
    for (int c = 0; c < l0 + 4 * FC; c++) begin
      if (c == l0) set_frame(VT, -1, HT);
      gen(h, v, px); step(1'b0, h, v, px);
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL shortframe_model c=%0d got %h want %h", c, obs, exp_vec); end
      if (err_line) el_cnt++;
      if (err_frame) begin
        ef_cnt++;
        if (ef_at < 0) begin ef_at = c; lk_before = prev_lk; lk_err = locked; end
      end else if (ef_at >= 0 && lk_rise < 0 && locked) lk_rise = c;
      prev_lk = locked;
    end
    total++;
    if (ef_cnt != 1 || el_cnt != 0) begin
      bad++; $display("FAIL shortframe_count got ef=%0d el=%0d want ef=1 el=0", ef_cnt, el_cnt);
    end
    total++; if (ef_at != l0) begin bad++; $display("FAIL shortframe_at got %0d want %0d", ef_at, l0); end
    total++;
    if ({lk_before, lk_err} !== 2'b10) begin bad++; $display("FAIL shortframe_drop got %b want 10", {lk_before, lk_err}); end
    total++; if (lk_rise != l0 + 3 * FC) begin bad++; $display("FAIL shortframe_relock got %0d want %0d", lk_rise, l0 + 3 * FC); end
  endtask

  task automatic test_timeout();
    logic h, v; logic [11:0] px;
    int el_cnt = 0, el_at = -1, ef_cnt = 0, lk_rise = -1;
    logic prev_lk, lk_before = 0, lk_err = 1;
    prev_lk = locked;
    for (int c = 0; c < 1100; c++) begin
      step(1'b0, 1'b1, 1'b1, 12'($urandom));
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL timeout_model c=%0d got %h want %h", c, obs, exp_vec); end
      if (err_line) begin
        el_cnt++;
        if (el_at < 0) begin el_at = c; lk_before = prev_lk; lk_err = locked; end
      end
      if (err_frame) ef_cnt++;
      prev_lk = locked;
    end
    total++; if (el_at != 1023 - HT) begin bad++; $display("FAIL timeout_at got %0d want %0d", el_at, 1023 - HT); end
    total++;
    if ({lk_before, lk_err} !== 2'b10) begin bad++; $display("FAIL timeout_drop got %b want 10", {lk_before, lk_err}); end
    g_p = 0; g_l = 0; set_frame(VT, -1, HT);
    for (int c = 0; c < 3 * FC; c++) begin
      gen(h, v, px); step(1'b0, h, v, px);
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL resume_model c=%0d got %h want %h", c, obs, exp_vec); end
      if (err_line) el_cnt++;
      if (err_frame) ef_cnt++;
      if (locked && lk_rise < 0) lk_rise = c;
    end
    total++;
    if (el_cnt != 1 || ef_cnt != 0) begin
      bad++; $display("FAIL timeout_count got el=%0d ef=%0d want el=1 ef=0", el_cnt, ef_cnt);
    end
    total++; if (lk_rise != 2 * FC) begin bad++; $display("FAIL resume_lock got %0d want %0d", lk_rise, 2 * FC); end
  endtask

  task automatic test_reset_mid();
    logic h, v; logic [11:0] px;
    int r, lk_rise = -1;
    r = 7 * HT + HS + int'($urandom_range(0, HT - HS - 1));
    for (int c = 0; c < 4 * FC; c++) begin
      gen(h, v, px); step(c == r, h, v, px);
      total++;
      if (obs !== exp_vec) begin bad++; $display("FAIL rstmid_model c=%0d got %h want %h", c, obs, exp_vec); end
      if (c == r) begin
        total++;
        if (obs !== 37'd0) begin bad++; $display("FAIL rstmid_outputs got %h want 0", obs); end
      end
      if (c > r && locked && lk_rise < 0) lk_rise = c;
    end
    total++; if (lk_rise != 3 * FC) begin bad++; $display("FAIL rstmid_relock got %0d want %0d", lk_rise, 3 * FC); end
  endtask

  task automatic test_random();
    logic h, v; logic [11:0] px;
    int nl, sl, n;
    rnd_pix = 1;
    for (int f = 0; f < 10; f++) begin
      nl = VT;
      if ($urandom_range(0, 3) == 0) nl = $urandom_range(0, 1) ? VT + 1 : VT - 1;
      sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      set_frame(nl, sl, HT - 3 + int'($urandom_range(0, 6)));
      n = frame_len();
      for (int c = 0; c < n; c++) begin
        gen(h, v, px); step(1'b0, h, v, px);
        total++;
        if (obs !== exp_vec) begin bad++; $display("FAIL random_model f=%0d c=%0d got %h want %h", f, c, obs, exp_vec); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_short_frame();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive side of the team's 640x480 VGA timing: samples incoming hsync/vsync/pixel data in the pixel clock domain.
- Recovers the pixel coordinates and a data-enable strobe, and checks the timing against the nominal 800x525 frame.
- Declares lock only after consecutive clean frames.
- Used to capture or loop back VGA streams and to self-check display timing in hardware.

Parameters:
- H_SYNC, 96, hsync low-pulse width in clocks
- H_BP, 48, clocks from end of hsync pulse to first active pixel
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, vsync low-pulse width in lines
- V_BP, 33, lines from end of vsync pulse to first active line
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive clean frames required to assert locked

Ports:
- clk  in  1  pixel clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- hsync  in  1  horizontal sync, active-low pulse
- vsync  in  1  vertical sync, active-low pulse, changes on the same clock as hsync falls
- pix_in  in  12  RGB444 pixel data, {R,G,B}
- h_addr  out  10  recovered column, 0..H_ACTIVE-1; 0 when de=0
- v_addr  out  10  recovered row, 0..V_ACTIVE-1; 0 when de=0
- de  out  1  pixel valid
- pix_out  out  12  pix_in delayed to align with h_addr/v_addr/de
- frame_start  out  1  one-cycle pulse at line 0, position 0
- locked  out  1  timing locked
- err_line  out  1  one-cycle pulse: line length error
- err_frame  out  1  one-cycle pulse: frame length error

Behaviour:
- Reset (synchronous, active-high, wins over all other events):
  - All outputs are 0.
  - pos, line, good_frames, the edge registers and the h_seen/v_seen flags are cleared.
  - State goes to UNLOCKED.
  - Reset mid-frame discards all progress; a new vsync edge is required before TRAINING starts.
- Edge detect:
  - Register hsync_d and vsync_d. Their reset value is 1, so a low input during reset does not create a false edge.
  - hfall = hsync_d & ~hsync.
  - vfall = vsync_d & ~vsync.
  - vpend is set on vfall and cleared on the next qualified hfall. A vfall on the same clock as an hfall qualifies that hfall.
- Horizontal counter pos (10 bit):
  - On hfall, pos goes to 0 and h_seen goes to 1.
  - Otherwise pos increments, saturating at 1023.
  - Line-length check: on any hfall with h_seen=1, measured period = pos+1. If period != H_TOTAL, pulse err_line.
  - Timeout: pos reaching 1023 pulses err_line once and clears h_seen.
- Vertical counter line (10 bit):
  - On a qualified hfall (vpend or same-cycle vfall), line goes to 0 and v_seen goes to 1.
  - Frame-length check: on a qualified hfall with v_seen=1, if line != V_TOTAL-1, pulse err_frame.
  - On an unqualified hfall, line increments, saturating at 1023.
- Active window:
  - act = h_seen & v_seen & locked.
  - pos in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = [144, 783].
  - line in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1] = [35, 514].
  - h_addr = pos-144 and v_addr = line-35, each 10 bits.
- Latency:
  - The counters are combinational from the sampling cycle.
  - All outputs are registered: exactly 1 clock after the hsync/vsync/pix_in sample they describe.
  - frame_start fires on the output cycle for the qualified hfall.
- Lock FSM:
  - UNLOCKED: on vfall, go to TRAINING with good_frames=0.
  - TRAINING: at each qualified hfall with v_seen=1, if there was no err_line and no err_frame since the previous qualified hfall, good_frames increments. When good_frames = LOCK_FRAMES, go to LOCKED; locked=1 from the next output cycle.
  - TRAINING: any err_line or err_frame sends the FSM to UNLOCKED.
  - LOCKED: any err_line or err_frame sends the FSM to UNLOCKED. locked and de drop on the output cycle carrying the error pulse.
- Simultaneous events:
  - An error and a frame completion in the same cycle: the error wins and the frame is not counted.
  - hfall while pos is saturated: pos restarts at 0 and err_line has already fired at saturation, so there is no second err_line pulse.

Test Plan:
- Nominal 800x525 stream from reset:
  - no err pulses;
  - locked rises 1 clock after the qualified hfall that starts frame 3;
  - the first de in frame 3 has h_addr=0, v_addr=0, one clock after pos=144, line=35;
  - the last de has h_addr=639, v_addr=479;
  - de is high for 307200 clocks per frame.
- Pixel alignment: drive pix_in = {pos[3:0], line[3:0], 4'hA} -> pix_out equals the value sampled one clock earlier, with matching h_addr/v_addr.
- One line shortened to 799 clocks while locked:
  - err_line pulses once;
  - locked and de fall on that output cycle;
  - relock happens after 2 further clean frames.
- Frame of 524 lines while locked -> err_frame at the qualified hfall, then UNLOCKED.
- hsync held high 1100 clocks -> err_line exactly once when pos hits 1023; no further pulses until hsync resumes.
- rst asserted for 1 clock mid-frame -> next clock all outputs 0 and locked=0; lock returns 1 clock after the qualified hfall starting the 3rd frame after the next vfall.
